ex_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It takes the forwarded operands and the decoded mul/div operation of the instruction currently in EX and holds the architectural HI/LO registers. It runs radix-2 iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO. Its `busy` output goes to the hazard unit, which stalls IF/ID/EX while a mul/div result is pending.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_iter_core.sv | 70 +++++++
 rtl/ex_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITER  = MDU_WIDTH;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } mdu_state_e;

   // True for the four iterative ops (MULT/MULTU/DIV/DIVU).
   function automatic logic is_iter_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one result bit per step.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   input  logic               step,
   output logic [2*WIDTH-1:0] result,
   output logic               last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic [CW-1:0]      cnt_q;
   logic               div_q;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_cand;
   logic [WIDTH:0]     div_diff;

   // One iteration of the selected algorithm.
   always_comb begin
      acc_d    = acc_q;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_cand = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_cand - {1'b0, opnd_q};
      if (div_q) begin
         // Remainder is always below the divisor, so a set top bit of the
         // difference can only mean the trial subtraction went negative.
         if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_d = {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // Operand load, per-step accumulator update and iteration counter.
   always_ff @(negedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
      end else if (load) begin
         acc_q  <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
         opnd_q <= is_div ? b_mag : a_mag;
         cnt_q  <= '0;
         div_q  <= is_div;
      end else if (step) begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   assign result = acc_q;
   assign last   = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: sequencing FSM, HI/LO registers, MTHI/MTLO,
// sign handling around the unsigned iterative core, cancel and reset.
//
// state | meaning
// IDLE  | no op in flight; accepts mul/div start or MTHI/MTLO write
// CALC  | core iterating, one bit per cycle
// FIN   | sign fix-up, HI/LO write, may accept a back-to-back start
module ex_muldiv_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2 * WIDTH;

   mdu_state_e       state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;
   logic             neg_res_q, neg_rem_q, div_zero_q, is_div_q;

   logic             load, step, last;
   logic [W2-1:0]    raw;

   logic             op_div, op_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

   // Magnitudes and signs of the incoming operands.
   always_comb begin
      op_div    = op[1];
      op_signed = ~op[0];
      a_neg     = op_signed & a[WIDTH-1];
      b_neg     = op_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .is_div (op_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .step   (step),
      .result (raw),
      .last   (last)
   );

   // Sign fix-up and HI/LO placement of the raw core result.
   always_comb begin
      prod_fix = neg_res_q ? -raw : raw;
      // Divide by zero yields an all-ones quotient regardless of signs.
      if (div_zero_q)
         quo_fix = '1;
      else
         quo_fix = neg_res_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -raw[W2-1:WIDTH] : raw[W2-1:WIDTH];
      res_hi   = is_div_q ? rem_fix : prod_fix[W2-1:WIDTH];
      res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
   end

   // Next-state, register write and core control decode.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !cancel) begin
               if (is_iter_op(op)) begin
                  load    = 1'b1;
                  state_d = ST_CALC;
               end else if (op == MDU_MTHI) begin
                  hi_d = a;
               end else if (op == MDU_MTLO) begin
                  lo_d = a;
               end
            end
         end
         ST_CALC: begin
            step = 1'b1;
            if (cancel)
               state_d = ST_IDLE;
            else if (last)
               state_d = ST_FIN;
         end
         ST_FIN: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               hi_d   = res_hi;
               lo_d   = res_lo;
               done_d = 1'b1;
               // Zero-bubble chaining: next mul/div latches while this one retires.
               if (start && is_iter_op(op)) begin
                  load    = 1'b1;
                  state_d = ST_CALC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, architectural HI/LO, done pulse and latched sign information.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         is_div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         if (load) begin
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (b == '0);
            is_div_q   <= op_div;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit. The DUT acts on falling edges; the bench
// drives and samples on rising edges.
module tb_ex_muldiv_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, cancel;
   logic [2:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         busy, done;

   int   n_tot = 0;
   int   n_bad = 0;
   logic b2b_ok = 1'b0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // The hazard unit only lets start coincide with busy at the FIN edge.
   always @(negedge clk) begin
      if (!rst)
         assert (!(start && busy) || b2b_ok) else $error("start raised while busy");
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 60) begin
         n++;
         @(posedge clk);
      end
   endtask

   task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
      int n;
      issue(o, x, y);
      wait_idle(n);
      chk({tag, "_lat"}, 64'(n), 64'd33);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      @(posedge clk);
      chk({tag, "_done_off"}, 64'(done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);

      run_md("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_md("mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div_negb",  MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_md("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_md("divu_z",    MDU_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
      run_md("div_z",     MDU_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
      run_md("divu_q",    MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

      issue(MDU_MTLO, 32'h0000_1234, 32'd0);
      chk("mtlo_lo", 64'(lo), 64'h1234);
      chk("mtlo_busy", 64'(busy), 64'd0);
      chk("mtlo_hi", 64'(hi), 64'd2);
      issue(MDU_MTHI, 32'h0000_ABCD, 32'd0);
      chk("mthi_hi", 64'(hi), 64'hABCD);
      chk("mthi_lo", 64'(lo), 64'h1234);

      issue(3'd6, 32'h5555_5555, 32'd1);
      chk("rsvd_busy", 64'(busy), 64'd0);
      chk("rsvd_hi", 64'(hi), 64'hABCD);
      chk("rsvd_lo", 64'(lo), 64'h1234);

      // Back-to-back: second op sampled on the same edge the first retires.
      issue(MDU_MULTU, 32'd5, 32'd6);
      repeat (32) @(posedge clk);
      start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd4; b2b_ok = 1'b1;
      @(posedge clk);
      start = 1'b0; b2b_ok = 1'b0;
      chk("b2b_first_done", 64'(done), 64'd1);
      chk("b2b_first_hi", 64'(hi), 64'd0);
      chk("b2b_first_lo", 64'(lo), 64'd30);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_idle(n);
      chk("b2b_lat", 64'(n), 64'd33);
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_hi", 64'(hi), 64'd0);
      chk("b2b_lo", 64'(lo), 64'd12);

      // Cancel mid-divide.
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      cancel = 1'b1;
      @(posedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      chk("cancel_hi", 64'(hi), 64'd0);
      chk("cancel_lo", 64'(lo), 64'd12);
      for (int i = 0; i < 30; i++) begin
         chk("cancel_nodone", 64'(done), 64'd0);
         @(posedge clk);
      end
      chk("cancel_lo_late", 64'(lo), 64'd12);

      // Cancel beats start in IDLE.
      @(posedge clk);
      start = 1'b1; cancel = 1'b1; op = MDU_MTHI; a = 32'hDEAD_BEEF;
      @(posedge clk);
      chk("cxmt_hi", 64'(hi), 64'd0);
      op = MDU_MULTU; a = 32'd9; b = 32'd9;
      @(posedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("cxmul_busy", 64'(busy), 64'd0);

      // Reset mid-multiply.
      issue(MDU_MULT, 32'hFFFF_FFFB, 32'd9);
      repeat (19) @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      rst = 1'b0;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_hi", 64'(hi), 64'd0);
      chk("mrst_lo", 64'(lo), 64'd0);
      run_md("after_rst", MDU_MULTU, 32'd2, 32'd2, 32'd0, 32'd4);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
